// File: rtl/trace_line_formatter.sv
// ============================================================================
// Module   : trace_line_formatter
// Purpose  : Snapshots an instruction word and NUM_CH data channels on capture
//            and streams them as ASCII hex lines over valid/ready.
// Option   : define TRACE_OVERRUN_CNT_EN to count ignored captures and append
//            an "O:xx" line after the channel lines.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trace_line_formatter #(
  parameter int          DATA_W   = 32,
  parameter int          NUM_CH   = 3,
  parameter logic [7:0]  EOL_BYTE = 8'h0A
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture,
  input  logic [31:0]              instruction,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     line_start,
  output logic                     busy,
  output logic [7:0]               overrun_cnt
);

  localparam int ND = DATA_W / 4;
`ifdef TRACE_OVERRUN_CNT_EN
  localparam int LAST_LINE = NUM_CH + 1;
`else
  localparam int LAST_LINE = NUM_CH;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LABEL, S_COLON, S_HEX, S_EOL} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              line_q, line_d;
  logic [3:0]              dig_q, dig_d;
  logic [31:0]             instr_q;
  logic [DATA_W-1:0]       ch_q [NUM_CH];

  logic                    w_xfer;
  logic                    w_accept;
  logic                    w_is_instr;
  logic                    w_is_ovr;
  logic [3:0]              w_dig_top;
  logic [63:0]             w_val;
  logic [3:0]              w_nib;
  logic [7:0]              w_hex;
  logic [7:0]              w_label;

  assign busy       = (state_q != S_IDLE);
  assign out_valid  = busy;
  assign line_start = (state_q == S_LABEL);
  assign w_xfer     = out_valid & out_ready;
  assign w_accept   = capture & (state_q == S_IDLE);
  assign w_is_instr = (line_q == 4'd0);

`ifdef TRACE_OVERRUN_CNT_EN
  logic [7:0] cnt_q, cnt_d, ovsnap_q;

  assign w_is_ovr    = (line_q == 4'(NUM_CH + 1));
  assign overrun_cnt = cnt_q;

  // Clearing on the overrun line's EOL takes priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (capture && busy && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    if (w_xfer && (state_q == S_EOL) && w_is_ovr) cnt_d = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= 8'h00;
      ovsnap_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
      if (w_xfer && (state_q == S_EOL) && (line_q == 4'(NUM_CH))) ovsnap_q <= cnt_d;
    end
  end
`else
  assign w_is_ovr    = 1'b0;
  assign overrun_cnt = 8'h00;
`endif

  always_comb begin
    w_val = '0;
    if (w_is_instr) begin
      w_val[31:0] = instr_q;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (line_q == 4'(k + 1)) w_val[DATA_W-1:0] = ch_q[k];
      end
`ifdef TRACE_OVERRUN_CNT_EN
      if (w_is_ovr) w_val[7:0] = ovsnap_q;
`endif
    end
  end

  always_comb begin
    w_nib = 4'h0;
    for (int d = 0; d < 16; d++) begin
      if (dig_q == 4'(d)) w_nib = w_val[d*4 +: 4];
    end
  end

  assign w_hex   = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
  // Channel k lives on line k+1, so its label '0'+k is 8'h2F plus the line index.
  assign w_label = w_is_instr ? 8'h49 : (w_is_ovr ? 8'h4F : (8'h2F + {4'h0, line_q}));

  always_comb begin
    if (w_is_instr)    w_dig_top = 4'd7;
    else if (w_is_ovr) w_dig_top = 4'd1;
    else               w_dig_top = 4'(ND - 1);
  end

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    dig_d    = dig_q;
    out_byte = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d = S_LABEL;
          line_d  = 4'd0;
        end
      end
      S_LABEL: begin
        out_byte = w_label;
        if (w_xfer) state_d = S_COLON;
      end
      S_COLON: begin
        out_byte = 8'h3A;
        if (w_xfer) begin
          state_d = S_HEX;
          dig_d   = w_dig_top;
        end
      end
      S_HEX: begin
        out_byte = w_hex;
        if (w_xfer) begin
          if (dig_q == 4'd0) state_d = S_EOL;
          else               dig_d   = dig_q - 4'd1;
        end
      end
      S_EOL: begin
        out_byte = EOL_BYTE;
        if (w_xfer) begin
          if (line_q == 4'(LAST_LINE)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_LABEL;
            line_d  = line_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      line_q  <= 4'd0;
      dig_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      dig_q   <= dig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= 32'h0;
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
    end else if (w_accept) begin
      instr_q <= instruction;
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= ch_data[k*DATA_W +: DATA_W];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trace_line_formatter.sv
// ============================================================================
// Module   : tb_trace_line_formatter
// Purpose  : Directed self-checking bench for trace_line_formatter (default
//            3x32 build and a 1x16 variant).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_trace_line_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture, out_ready, out_valid, line_start, busy;
  logic [31:0] instruction;
  logic [95:0] ch_data;
  logic [7:0]  out_byte, overrun_cnt;

  logic        cap_b, rdy_b, valid_b, ls_b, busy_b;
  logic [31:0] instr_b;
  logic [15:0] ch_b;
  logic [7:0]  byte_b, ovr_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] got [$];
  logic       gls [$];

  always #5 clk = ~clk;

  trace_line_formatter u_dut_a (
    .clk(clk), .rst_n(rst_n), .capture(capture), .instruction(instruction),
    .ch_data(ch_data), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .line_start(line_start), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  trace_line_formatter #(.DATA_W(16), .NUM_CH(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .capture(cap_b), .instruction(instr_b),
    .ch_data(ch_b), .out_byte(byte_b), .out_valid(valid_b),
    .out_ready(rdy_b), .line_start(ls_b), .busy(busy_b),
    .overrun_cnt(ovr_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Captures a snapshot on the selected DUT and collects its stream.
  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic run(input bit sel, input int mode, input bit inject,
                     output int iters, output bit stable_ok);
    logic [7:0] held;
    bit         hold;
    got.delete();
    gls.delete();
    hold      = 1'b0;
    held      = 8'h00;
    stable_ok = 1'b1;
    iters     = 0;
    @(negedge clk);
    if (sel) begin
      instr_b = 32'hFFFFFFFF;
      ch_b    = 16'hA5C3;
      cap_b   = 1'b1;
    end else begin
      instruction = 32'h00A00093;
      ch_data     = {32'h00000000, 32'hDEADBEEF, 32'h12345678};
      capture     = 1'b1;
    end
    @(negedge clk);
    cap_b   = 1'b0;
    capture = 1'b0;
    check(sel ? "B_latency_valid" : "A_latency_valid", sel ? valid_b : out_valid, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic       v, r, ls;
      logic [7:0] b;
      v  = sel ? valid_b : out_valid;
      b  = sel ? byte_b : out_byte;
      ls = sel ? ls_b : line_start;
      if (!v) break;
      iters++;
      r = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sel) rdy_b = r;
      else     out_ready = r;
      capture = 1'b0;
      if (inject && r && (got.size() == 5 || got.size() == 43)) begin
        capture     = 1'b1;
        instruction = 32'hCAFEF00D;
        ch_data     = '1;
      end
      if (hold && (b !== held)) stable_ok = 1'b0;
      if (r) begin
        got.push_back(b);
        gls.push_back(ls);
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        held = b;
      end
      @(negedge clk);
    end
    capture = 1'b0;
    check(sel ? "B_busy_done" : "A_busy_done", sel ? busy_b : busy, 0);
  endtask

  task automatic compare_stream(input string tag, input string exp);
    check({tag, "_len"}, got.size(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      logic [7:0] e, g;
      logic       el, gl;
      e  = exp[i];
      g  = (i < got.size()) ? got[i] : 8'h00;
      gl = (i < got.size()) ? gls[i] : 1'b0;
      el = 1'b1;
      if (i > 0) el = (exp[i-1] == 8'h0A);
      check($sformatf("%s_byte%0d", tag, i), g, e);
      check($sformatf("%s_ls%0d", tag, i), gl, el);
    end
  endtask

  initial begin
    string exp_a, exp_b;
    int    iters, n;
    bit    stable_ok, quiet;
    exp_a = "I:00A00093\n0:12345678\n1:DEADBEEF\n2:00000000\n";
    exp_b = "I:FFFFFFFF\n0:A5C3\n";

    rst_n = 1'b0; capture = 1'b0; out_ready = 1'b0;
    instruction = 32'h0; ch_data = '0;
    cap_b = 1'b0; rdy_b = 1'b0; instr_b = 32'h0; ch_b = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_byte", out_byte, 8'h00);
    check("rst_line_start", line_start, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_cnt, 8'h00);
    check("rst_B_valid", valid_b, 0);
    rst_n = 1'b1;

    // Ready held high: 44 bytes on consecutive cycles.
    run(1'b0, 0, 1'b0, iters, stable_ok);
    compare_stream("dflt", exp_a);
    check("dflt_cycles", iters, 44);

    // Backpressure with ready pattern 1,0,0,1.
    run(1'b0, 1, 1'b0, iters, stable_ok);
    compare_stream("bp", exp_a);
    check("bp_stable", stable_ok, 1);

    // Captures mid-stream and on the last transfer must be ignored.
    run(1'b0, 0, 1'b1, iters, stable_ok);
    compare_stream("ign", exp_a);
    check("ign_valid_after", out_valid, 0);
    check("ign_overrun", overrun_cnt, 8'h00);

    // Reset after byte 15 aborts the stream.
    @(negedge clk);
    instruction = 32'h00A00093;
    ch_data     = {32'h00000000, 32'hDEADBEEF, 32'h12345678};
    capture     = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 16; cyc++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    check("rst_mid_count", n, 16);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    check("rst_mid_quiet", quiet, 1);
    run(1'b0, 0, 1'b0, iters, stable_ok);
    compare_stream("restart", exp_a);

    // DATA_W=16, NUM_CH=1 variant.
    run(1'b1, 0, 1'b0, iters, stable_ok);
    compare_stream("var", exp_b);
    check("var_cycles", iters, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
